// File: rtl/pg_chunk_accumulator_if.sv
// Handshake bundle for pg_chunk_accumulator: an operand stream in, a result out.
interface pg_chunk_accumulator_if #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 20
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_first;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid, in_data, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  // Accumulator side
  modport slave (
    input  in_valid, in_data, in_first, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/pg_chunk_accumulator.sv
// Multi-cycle unsigned accumulator. Each accepted operand is added into the
// ACC_W-bit accumulator CHUNK bits per clock using full adders built from two
// Peres gates each; the carry between chunks is held in a register so the
// combinational path is only CHUNK cells deep.
module pg_chunk_accumulator #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 20,
  parameter int CHUNK = 4
) (
  input logic                  clk,
  input logic                  rst,
  pg_chunk_accumulator_if.slave bus
);

  localparam int NCH = ACC_W / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] op_q, op_d;
  logic             last_q, last_d;

  // Peres gate P(a,b,c) = (a, a^b, a&b ^ c). The P output is a copy of a and
  // is never needed here, so only {Q, R} are returned.
  function automatic logic [1:0] peres_qr(input logic a, input logic b, input logic c);
    return {a ^ b, (a & b) ^ c};
  endfunction

  logic [CHUNK-1:0] acc_sl;
  logic [CHUNK-1:0] op_sl;
  logic [CHUNK-1:0] sum_sl;
  logic [CHUNK:0]   cc;

  assign acc_sl = acc_q[k_q * CHUNK +: CHUNK];
  assign op_sl  = op_q[k_q * CHUNK +: CHUNK];
  assign cc[0]  = carry_q;

  // One full adder per bit: gate 1 gives a^b and a&b, gate 2 folds in the
  // carry to give sum = a^b^cin and cout = (a^b)&cin ^ a&b.
  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_cell
    logic [1:0] g1_qr;
    logic [1:0] g2_qr;
    assign g1_qr      = peres_qr(acc_sl[gi], op_sl[gi], 1'b0);
    assign g2_qr      = peres_qr(g1_qr[1], cc[gi], g1_qr[0]);
    assign sum_sl[gi] = g2_qr[1];
    assign cc[gi+1]   = g2_qr[0];
  end

  // Async reset forces IDLE, but nothing may be accepted while it is held.
  assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_data  = acc_q;
  assign bus.out_ovf   = ovf_q;

  // Next-state logic: accept in IDLE, one chunk per cycle in ADD, wait in HOLD.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    op_d    = op_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_d    = ACC_W'(bus.in_data[WIDTH-1:0]);
          last_d  = bus.in_last;
          k_d     = '0;
          carry_d = 1'b0;
          state_d = ST_ADD;
          if (bus.in_first) begin
            acc_d = '0;
            ovf_d = 1'b0;
          end
        end
      end
      ST_ADD: begin
        acc_d[k_q * CHUNK +: CHUNK] = sum_sl;
        carry_d = cc[CHUNK];
        k_d     = k_q + KW'(1);
        if (k_q == KW'(NCH - 1)) begin
          // Carry out of the top chunk is the wrap of the whole accumulator.
          ovf_d   = ovf_q | cc[CHUNK];
          k_d     = '0;
          state_d = last_q ? ST_HOLD : ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any add in progress and clears the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      op_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      op_q    <= op_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_pg_chunk_accumulator.sv
// Directed bench for pg_chunk_accumulator with hand-computed expected sums.
module tb_pg_chunk_accumulator;

  localparam int WIDTH = 16;
  localparam int ACC_W = 20;
  localparam int CHUNK = 4;
  localparam int NCH   = ACC_W / CHUNK;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pg_chunk_accumulator_if #(.WIDTH(WIDTH), .ACC_W(ACC_W)) bus ();

  pg_chunk_accumulator #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one operand, then follow it until the add finishes: with last the
  // result must appear NCH edges after accept, otherwise in_ready must return
  // NCH edges after accept. Nothing may look ready/valid in between.
  task automatic send_op(input string tag, input logic [15:0] data,
                         input logic first, input logic last);
    int cyc;
    int bad;
    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!bus.in_ready) begin
      check_eq({tag, "_accept_timeout"}, 32'd0, 32'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_first = first;
    bus.in_last  = last;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    cyc = 0;
    bad = 0;
    forever begin
      if (last ? bus.out_valid : bus.in_ready) break;
      if (bus.in_ready || bus.out_valid) bad++;
      if (cyc >= 50) break;
      @(posedge clk); #1;
      cyc++;
    end
    check_eq({tag, "_latency"}, 32'(cyc), 32'(NCH));
    check_eq({tag, "_busy"}, 32'(bad), 32'd0);
  endtask

  // Check the held result, complete the output handshake, check return to IDLE.
  task automatic collect(input string tag, input logic [19:0] exp_data, input logic exp_ovf);
    check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_out_data"}, 32'(bus.out_data), 32'(exp_data));
    check_eq({tag, "_out_ovf"}, 32'(bus.out_ovf), 32'(exp_ovf));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int bad;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_first  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset values
    @(posedge clk); #1;
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
    check_eq("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // Single operand, first+last
    send_op("ffff", 16'hFFFF, 1'b1, 1'b1);
    collect("ffff", 20'h0FFFF, 1'b0);

    // Three-operand sum: 0x1234 + 0x0001 + 0xFFFF = 0x11234
    send_op("seq_a", 16'h1234, 1'b1, 1'b0);
    send_op("seq_b", 16'h0001, 1'b0, 1'b0);
    send_op("seq_c", 16'hFFFF, 1'b0, 1'b1);
    collect("seq", 20'h11234, 1'b0);

    // Carry crossing the chunk 0 / chunk 1 boundary
    send_op("cb_a", 16'h000F, 1'b1, 1'b0);
    send_op("cb_b", 16'h0001, 1'b0, 1'b1);
    collect("cb", 20'h00010, 1'b0);

    // 17 x 0xFFFF = 0x10FFEF, wraps to 0x0FFEF with overflow
    for (int i = 0; i < 17; i++) begin
      send_op("wrap", 16'hFFFF, (i == 0), (i == 16));
    end
    collect("wrap", 20'h0FFEF, 1'b1);
    send_op("after_wrap", 16'h0002, 1'b1, 1'b1);
    collect("after_wrap", 20'h00002, 1'b0);

    // Backpressure: result held, offered operands ignored
    send_op("bp", 16'h0007, 1'b1, 1'b1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_data  = 16'h0100;
      bus.in_first = 1'b1;
      bus.in_last  = 1'b1;
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 20'h00007 ||
          bus.out_ovf !== 1'b0 || bus.in_ready !== 1'b0) bad++;
    end
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    check_eq("bp_hold_stable", 32'(bad), 32'd0);
    collect("bp", 20'h00007, 1'b0);
    // Continues the previous sum: proves no held-off operand was taken
    send_op("bp_cont", 16'h0005, 1'b0, 1'b1);
    collect("bp_cont", 20'h0000C, 1'b0);

    // Reset while chunk k=2 is being processed
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h3333;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_eq("arst_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("arst_out_data", 32'(bus.out_data), 32'd0);
    check_eq("arst_out_ovf", 32'(bus.out_ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("arst_rel_ready", 32'(bus.in_ready), 32'd1);
    send_op("post_rst", 16'h0005, 1'b1, 1'b1);
    collect("post_rst", 20'h00005, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
